// File: rtl/cms_pkg.sv
// Shared constants for the trace gate: control register map, gate state
// encodings and address-window mode codes.
package cms_pkg;

  localparam int ADDR_START_EN        = 'h00;
  localparam int ADDR_END_EN          = 'h01;
  localparam int ADDR_START_ADDR      = 'h02;
  localparam int ADDR_END_ADDR        = 'h03;
  localparam int ADDR_RESUME          = 'h04;
  localparam int ADDR_CLR_DROP        = 'h05;
  localparam int ADDR_RANGE_LO_BASE   = 'h10;
  localparam int ADDR_RANGE_HI_BASE   = 'h11;
  localparam int ADDR_RANGE_MODE_BASE = 'h30;

  localparam logic [1:0] GATE_ARMED   = 2'd0;
  localparam logic [1:0] GATE_TRACING = 2'd1;
  localparam logic [1:0] GATE_HALTED  = 2'd2;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_INCLUDE = 2'd1;
  localparam logic [1:0] MODE_EXCLUDE = 2'd2;

endpackage

// File: rtl/cms_stream_fifo.sv
// Synchronous first-word-fall-through FIFO; an extra pointer bit separates
// full from empty and the head entry drives pop_data directly.
module cms_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LEVEL);
  assign valid    = (level != '0);
  assign pop_data = valid ? mem[rd_ptr[AW-1:0]] : '0;

  // NOTE: storage has no reset; only the pointers do, and pop_data is forced
  // to zero while empty so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && valid)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cms_trace_gate.sv
// Trace qualifier: start/end/WFI gate state machine plus include/exclude
// address windows, feeding an AXI-Stream FIFO with tlast and drop accounting.
module cms_trace_gate
  import cms_pkg::*;
#(
  parameter int          XLEN            = 64,
  parameter int          NUM_RANGES      = 4,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [31:0] WFI_INSTR       = 32'h0000_0001,
  parameter int          CTRL_ADDR_WIDTH = 8,
  parameter int          CTRL_DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   instr,
  input  logic [XLEN-1:0]               pc,
  input  logic                          pc_valid,
  input  logic [CTRL_ADDR_WIDTH-1:0]    ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0]    ctrl_wdata,
  input  logic                          ctrl_write_enable,
  input  logic [31:0]                   tlast_interval,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic [XLEN+31:0]              M_AXIS_tdata,
  output logic                          M_AXIS_tlast,
  output logic [31:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    gate_state
);

  localparam int ENTRY_W = XLEN + 33;

  logic                  start_en, end_en;
  logic [XLEN-1:0]       start_addr, end_addr;
  logic [XLEN-1:0]       range_lo   [NUM_RANGES];
  logic [XLEN-1:0]       range_hi   [NUM_RANGES];
  logic [1:0]            range_mode [NUM_RANGES];
  logic [1:0]            state, state_nxt;
  logic [31:0]           beat_cnt;

  logic wr_start_en, wr_end_en, wr_start_addr, wr_end_addr, wr_resume, wr_clr_drop;
  logic [NUM_RANGES-1:0] wr_lo, wr_hi, wr_mode;
  logic any_incl, in_incl, in_excl, range_pass;
  logic is_wfi, start_hit, end_hit, eligible, push, drop, push_tlast, fifo_full;
  logic [ENTRY_W-1:0] head;

  function automatic logic addr_is(input logic [CTRL_ADDR_WIDTH-1:0] a, input int target);
    return a == CTRL_ADDR_WIDTH'(target);
  endfunction

  // NOTE: every combinational output gets a default before any conditional
  // update, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_start_en   = ctrl_write_enable && addr_is(ctrl_addr, ADDR_START_EN);
    wr_end_en     = ctrl_write_enable && addr_is(ctrl_addr, ADDR_END_EN);
    wr_start_addr = ctrl_write_enable && addr_is(ctrl_addr, ADDR_START_ADDR);
    wr_end_addr   = ctrl_write_enable && addr_is(ctrl_addr, ADDR_END_ADDR);
    wr_resume     = ctrl_write_enable && addr_is(ctrl_addr, ADDR_RESUME);
    wr_clr_drop   = ctrl_write_enable && addr_is(ctrl_addr, ADDR_CLR_DROP);
    wr_lo   = '0;
    wr_hi   = '0;
    wr_mode = '0;
    for (int i = 0; i < NUM_RANGES; i++) begin
      wr_lo[i]   = ctrl_write_enable && addr_is(ctrl_addr, ADDR_RANGE_LO_BASE + 2*i);
      wr_hi[i]   = ctrl_write_enable && addr_is(ctrl_addr, ADDR_RANGE_HI_BASE + 2*i);
      wr_mode[i] = ctrl_write_enable && addr_is(ctrl_addr, ADDR_RANGE_MODE_BASE + i);
    end
  end

  // An inverted window (lower > upper) fails both compares and matches nothing.
  always_comb begin
    any_incl = 1'b0;
    in_incl  = 1'b0;
    in_excl  = 1'b0;
    for (int i = 0; i < NUM_RANGES; i++) begin
      if (range_mode[i] == MODE_INCLUDE) begin
        any_incl = 1'b1;
        if (pc >= range_lo[i] && pc <= range_hi[i]) in_incl = 1'b1;
      end
      if (range_mode[i] == MODE_EXCLUDE && pc >= range_lo[i] && pc <= range_hi[i])
        in_excl = 1'b1;
    end
    range_pass = (!any_incl || in_incl) && !in_excl;
  end

  always_comb begin
    is_wfi    = (instr == WFI_INSTR);
    start_hit = start_en && (pc == start_addr);
    end_hit   = end_en && (pc == end_addr);
    eligible  = pc_valid && range_pass &&
                (state == GATE_TRACING || (state == GATE_ARMED && start_hit));
    push       = eligible && !fifo_full;
    drop       = eligible && fifo_full;
    push_tlast = is_wfi || (tlast_interval != 32'd0 && beat_cnt == tlast_interval - 32'd1);

    state_nxt = state;
    if (pc_valid) begin
      if (is_wfi)                                state_nxt = GATE_HALTED;
      else if (state == GATE_ARMED && start_hit) state_nxt = GATE_TRACING;
      else if (state == GATE_TRACING && end_hit) state_nxt = GATE_ARMED;
    end
    // Effective control writes take precedence over pc-driven transitions.
    if (wr_start_en && state != GATE_HALTED)
      state_nxt = ctrl_wdata[0] ? GATE_ARMED : GATE_TRACING;
    if (wr_resume && state == GATE_HALTED)
      state_nxt = start_en ? GATE_ARMED : GATE_TRACING;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GATE_TRACING;
      start_en   <= 1'b0;
      end_en     <= 1'b0;
      start_addr <= '0;
      end_addr   <= '1;
      beat_cnt   <= '0;
      drop_count <= '0;
      for (int i = 0; i < NUM_RANGES; i++) begin
        range_lo[i]   <= '0;
        range_hi[i]   <= '1;
        range_mode[i] <= MODE_OFF;
      end
    end else begin
      state <= state_nxt;
      if (wr_start_en)   start_en   <= ctrl_wdata[0];
      if (wr_end_en)     end_en     <= ctrl_wdata[0];
      if (wr_start_addr) start_addr <= ctrl_wdata[XLEN-1:0];
      if (wr_end_addr)   end_addr   <= ctrl_wdata[XLEN-1:0];
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (wr_lo[i])   range_lo[i]   <= ctrl_wdata[XLEN-1:0];
        if (wr_hi[i])   range_hi[i]   <= ctrl_wdata[XLEN-1:0];
        if (wr_mode[i]) range_mode[i] <= ctrl_wdata[1:0];
      end
      if (push) beat_cnt <= push_tlast ? 32'd0 : beat_cnt + 32'd1;
      if (wr_clr_drop)                       drop_count <= '0;
      else if (drop && drop_count != '1)     drop_count <= drop_count + 32'd1;
    end
  end

  cms_stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_tlast, pc, instr}),
    .full      (fifo_full),
    .pop       (M_AXIS_tready),
    .valid     (M_AXIS_tvalid),
    .pop_data  (head),
    .level     (fifo_level)
  );

  assign M_AXIS_tdata = head[XLEN+31:0];
  assign M_AXIS_tlast = head[XLEN+32];
  assign gate_state   = state;

endmodule
